// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// hands {inst, pc, fault} to the core over a valid/ready handshake.
module ifu_fetch #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_fault
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic            drop, drop_nxt;
  logic            latch_rsp;
  logic            req_fire;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign imem_req_addr    = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_nxt;
  end

  // Redirect takes priority in every state; a redirect that races an
  // in-flight request marks exactly one response for discard via drop.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    latch_rsp    = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect_valid) fetch_pc_nxt = redirect_aligned;
        if (req_fire) begin
          state_nxt = S_WAIT;
          drop_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_aligned;
          if (imem_rsp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            latch_rsp = 1'b1;
            state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_aligned;
          state_nxt    = S_REQ;
        end else if (inst_ready) begin
          fetch_pc_nxt = pc + XLEN'(4);
          state_nxt    = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    inst_valid = (state == S_OUT);
  end

  // Request valid is registered so it stays low for the first cycle after
  // reset release even though the state is already REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc       <= RESET_PC;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst           <= '0;
      pc             <= RESET_PC;
      inst_fault     <= 1'b0;
    end else begin
      fetch_pc       <= fetch_pc_nxt;
      drop           <= drop_nxt;
      imem_req_valid <= (state_nxt == S_REQ);
      if (latch_rsp) begin
        inst       <= imem_rsp_err ? '0 : imem_rsp_data;
        pc         <= fetch_pc;
        inst_fault <= imem_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a transaction-level model of the PC stream
// and memory responder predicts fired addresses and delivered instructions.
module tb_ifu_fetch;
  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, pc;

  always #5 clk = ~clk;

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .inst_fault(inst_fault)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        inst_q[$];
  logic [31:0] addr_q[$];
  int          acc_cyc[$];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] out_addr = '0;
  int          epoch = 0, out_epoch = 0, wait_cnt = 0;
  bit          outstanding = 0;
  bit          mon_en = 0;
  int          cyc = 0, acc_count = 0;

  // stimulus knobs (percentages / latencies)
  int          redir_pct = 0, ready_pct = 100, irdy_pct = 100, err_pct = 0, spur_pct = 0;
  int          min_lat = 0, max_lat = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_data = '0;
  bit          redir_now = 0;
  logic [31:0] redir_target = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      2:       r = RESET_PC + $urandom_range(0, 63);
      default: r = $urandom_range(0, 15);
    endcase
    return r;
  endfunction

  // monitor: checks everything the DUT presents against the queues
  bit   prev_iv = 0, prev_rv = 0;
  exp_t e;
  logic [31:0] ea;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_iv = 0;
      prev_rv = 0;
    end else begin
      if (prev_iv) chk("inst_valid_hold", inst_valid, 1);
      if (prev_rv) chk("req_valid_hold", imem_req_valid, 1);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_unexpected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          chk("req_addr", imem_req_addr, ea);
        end
      end
      if (inst_valid && !redirect_valid) chk("inst_orphan", inst_q.size() != 0, 1);
      if (inst_valid && inst_ready && !redirect_valid && inst_q.size() != 0) begin
        e = inst_q.pop_front();
        chk("inst", inst, e.inst);
        chk("pc", pc, e.pc);
        chk("inst_fault", inst_fault, e.fault);
        acc_count++;
        acc_cyc.push_back(cyc);
      end
      prev_iv = inst_valid && !inst_ready && !redirect_valid;
      prev_rv = imem_req_valid && !imem_req_ready && !redirect_valid;
    end
  end

  // one cycle of stimulus; model updates reflect what the coming edge does
  task automatic step();
    logic        redir, rr, rsp, err, irdy, fire;
    logic [31:0] rpc, data;
    @(posedge clk); #1;
    cyc++;
    redir = redir_now || ($urandom_range(0, 99) < redir_pct);
    rpc   = redir_now ? redir_target : pick_pc();
    redir_now = 0;
    rr    = $urandom_range(0, 99) < ready_pct;
    irdy  = $urandom_range(0, 99) < irdy_pct;
    data  = use_fixed ? fixed_data : $urandom;
    rsp   = 0;
    err   = 0;
    if (outstanding) begin
      chk("req_while_busy", imem_req_valid, 0);
      if (wait_cnt == 0) begin
        rsp = 1;
        err = $urandom_range(0, 99) < err_pct;
        outstanding = 0;
        if (!redir && out_epoch == epoch)
          inst_q.push_back('{inst: (err ? 32'h0 : data), pc: out_addr, fault: err});
      end else begin
        wait_cnt--;
      end
    end else if ($urandom_range(0, 99) < spur_pct) begin
      rsp = 1;
      err = $urandom_range(0, 1);
    end
    fire = imem_req_valid && rr;
    if (fire) begin
      addr_q.push_back(exp_pc);
      outstanding = 1;
      wait_cnt    = $urandom_range(min_lat, max_lat);
      out_addr    = exp_pc;
      out_epoch   = epoch;
    end
    if (inst_valid && irdy && !redir) exp_pc = exp_pc + 32'd4;
    if (redir) begin
      epoch++;
      exp_pc = rpc & 32'hFFFF_FFFC;
      inst_q.delete();
    end
    imem_req_ready = rr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = irdy;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 0;
    redirect_valid = 0;
    redirect_pc    = '0;
    inst_ready     = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst    = 0;
    mon_en = 0;
    idle_inputs();
    outstanding = 0;
    addr_q.delete();
    inst_q.delete();
    exp_pc = RESET_PC;
    epoch++;
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst_fault", inst_fault, 0);
    @(posedge clk); #1;
    rst    = 1;
    mon_en = 1;
    // stale response after release must be ignored
    imem_rsp_valid = 1;
    imem_rsp_data  = 32'hDEAD_BEEF;
  endtask

  task automatic run_accepts(int n);
    int start, i;
    start = acc_count;
    i = 0;
    while (acc_count - start < n && i < 300) begin
      step();
      i++;
    end
    chk("accept_budget", acc_count - start >= n, 1);
  endtask

  task automatic wait_fire();
    int i;
    i = 0;
    while (!outstanding && i < 50) begin
      step();
      i++;
    end
    chk("fire_budget", outstanding, 1);
  endtask

  initial begin
    int base;
    idle_inputs();
    repeat (2) @(posedge clk);
    apply_reset();

    // first fetch with fixed data, then back-to-back throughput
    use_fixed  = 1;
    fixed_data = 32'h0000_0413;
    run_accepts(3);
    chk("spacing_1", acc_cyc[1] - acc_cyc[0], 3);
    chk("spacing_2", acc_cyc[2] - acc_cyc[1], 3);
    use_fixed = 0;

    // memory stalls the request for four cycles
    ready_pct = 0;
    repeat (4) step();
    ready_pct = 100;
    run_accepts(1);

    // redirect while waiting for the response
    min_lat = 2;
    max_lat = 2;
    wait_fire();
    redir_now    = 1;
    redir_target = 32'h8000_1002;
    step();
    run_accepts(2);
    min_lat = 0;
    max_lat = 0;

    // faulting fetch
    err_pct = 100;
    run_accepts(1);
    err_pct = 0;

    // PC wrap, then reset in the middle of a wait
    redir_now    = 1;
    redir_target = 32'hFFFF_FFFC;
    run_accepts(2);
    min_lat = 3;
    max_lat = 3;
    wait_fire();
    apply_reset();
    min_lat = 0;
    run_accepts(1);

    // randomized traffic with occasional resets
    redir_pct = 6;
    ready_pct = 70;
    irdy_pct  = 70;
    err_pct   = 10;
    spur_pct  = 5;
    max_lat   = 3;
    base = acc_count;
    for (int blk = 0; blk < 3; blk++) begin
      repeat (1000) step();
      apply_reset();
    end
    chk("random_progress", acc_count - base > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
